// File: rtl/shift_register_piso_32bit.sv
// Free-running parallel-in/serial-out shift register.
// Loads PI at the start of each frame, shifts it out one bit per clock and
// reloads right after the last bit, so consecutive frames have no gap.
module shift_register_piso_32bit #(
  parameter int   WIDTH     = 32,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0,
  localparam int  CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] PI,
  output logic             SO,
  output logic             FS,
  output logic             LB,
  output logic [CW-1:0]    BIT_CNT,
  output logic             VALID
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    cnt;
  logic             loaded;
  logic             load;

  // A load happens on the first edge after reset and right after the last bit.
  assign load = !loaded || (cnt == LAST);

  // Shift direction is fixed at elaboration; FILL enters the vacated end.
  generate
    if (MSB_FIRST) begin : g_msb
      if (WIDTH > 1) begin : g_w
        assign sr_shifted = {sr[WIDTH-2:0], FILL};
      end else begin : g_1
        assign sr_shifted = FILL;
      end
      assign SO = sr[WIDTH-1];
    end else begin : g_lsb
      if (WIDTH > 1) begin : g_w
        assign sr_shifted = {FILL, sr[WIDTH-1:1]};
      end else begin : g_1
        assign sr_shifted = FILL;
      end
      assign SO = sr[0];
    end
  endgenerate

  // Data register, bit counter and loaded flag; reset aborts any frame.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      sr     <= '0;
      cnt    <= '0;
      loaded <= 1'b0;
    end else if (load) begin
      sr     <= PI;
      cnt    <= '0;
      loaded <= 1'b1;
    end else begin
      sr     <= sr_shifted;
      cnt    <= cnt + 1'b1;
    end
  end

  // Status outputs come only from registered state.
  assign VALID   = loaded;
  assign FS      = loaded && (cnt == '0);
  assign LB      = loaded && (cnt == LAST);
  assign BIT_CNT = cnt;

endmodule

// File: tb/tb_shift_register_piso_32bit.sv
// Bench for shift_register_piso_32bit: frame table plus scoreboard queue of
// expected per-bit outputs, and a hand-written mid-frame reset sequence.
module tb_shift_register_piso_32bit;

  logic        C = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] PI = 32'hD0492087;
  logic        SO, FS, LB, VALID;
  logic [4:0]  BIT_CNT;

  int errors = 0;
  int checks = 0;

  shift_register_piso_32bit dut (
    .C(C), .RST_N(RST_N), .PI(PI), .SO(SO), .FS(FS), .LB(LB),
    .BIT_CNT(BIT_CNT), .VALID(VALID)
  );

  always #5 C = ~C;

  typedef struct packed {
    logic       valid;
    logic       fs;
    logic       lb;
    logic [4:0] cnt;
    logic       so;
  } exp_t;

  typedef struct {
    logic [31:0] pi;
    logic [31:0] bits;  // expected SO stream, first bit in [31]
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {valid,fs,lb,cnt,so}=%b required %b at %0t", name, got, want, $time);
    end
  endtask

  // Queue the 32 expected bit slots of a frame carrying stream 'bits'.
  task automatic push_frame(input logic [31:0] bits);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.valid = 1'b1;
      e.fs    = (k == 0);
      e.lb    = (k == 31);
      e.cnt   = 5'(k);
      e.so    = bits[31-k];
      sb.push_back(e);
    end
  endtask

  // Advance one clock and compare the outputs against the scoreboard head.
  task automatic step_check(input string name);
    exp_t e;
    @(posedge C);
    @(negedge C);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at %0t", name, $time);
    end else begin
      e = sb.pop_front();
      check(name, {VALID, FS, LB, BIT_CNT, SO}, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected streams; the first is the serial sequence listed bit by bit.
    tbl[0] = '{32'hD0492087, 32'b1101_0000_0100_1001_0010_0000_1000_0111};
    tbl[1] = '{32'hD0492087, 32'hD0492087};
    tbl[2] = '{32'h0000_0001, 32'h0000_0001};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000};
    tbl[5] = '{32'h8000_0001, 32'h8000_0001};
    tbl[6] = '{32'h5A5A_C3C3, 32'h5A5A_C3C3};

    // Reset held: outputs stay zero across clock edges.
    #1 RST_N = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      check("reset_hold", {VALID, FS, LB, BIT_CNT, SO}, 9'b0);
    end

    // Release between edges; next edge loads the first frame.
    PI = tbl[0].pi;
    push_frame(tbl[0].bits);
    RST_N = 1'b1;

    for (int f = 0; f < 7; f++) begin
      for (int k = 0; k < 32; k++) begin
        step_check($sformatf("frame%0d_bit%0d", f, k));
        // Mid-frame PI changes must not disturb the word in flight.
        if (f < 6) begin
          if (k == 5) begin
            PI = tbl[f+1].pi;
            push_frame(tbl[f+1].bits);
          end else if (k == 18) begin
            PI = $urandom;
          end else if (k == 26) begin
            PI = tbl[f+1].pi;
          end
        end
      end
    end

    // Frame that gets cut by an asynchronous reset at bit 12.
    PI = 32'hC001_D00D;
    push_frame(32'hC001_D00D);
    for (int k = 0; k <= 12; k++)
      step_check($sformatf("pre_reset_bit%0d", k));
    #2 RST_N = 1'b0;
    #1 check("async_reset_now", {VALID, FS, LB, BIT_CNT, SO}, 9'b0);
    sb.delete();
    @(negedge C);
    check("async_reset_held", {VALID, FS, LB, BIT_CNT, SO}, 9'b0);

    // Fresh load after release, then a reload with no idle cycle.
    PI = 32'h9000_0003;
    push_frame(32'h9000_0003);
    RST_N = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step_check($sformatf("post_reset_bit%0d", k));
      if (k == 10) begin
        PI = 32'h0F0F_F0F0;
        push_frame(32'h0F0F_F0F0);
      end
    end
    for (int k = 0; k < 32; k++)
      step_check($sformatf("last_frame_bit%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_register_piso_32bit.md
Name: shift_register_piso_32bit

Overview:
- Free-running 32-bit parallel-in/serial-out shift register used to serialise a parallel word onto a single-bit line.
- The block captures the parallel input at the start of each frame and shifts it out MSB first, one bit per clock.
- It reloads automatically after the last bit, with no gap between frames, so it needs no load or enable strobe.
- Frame-position status outputs let downstream logic align to word boundaries.

Parameters:
- WIDTH, 32, word length in bits; everything below is stated for the default.
- MSB_FIRST, 1: 1 = shift out PI[WIDTH-1] first; 0 = shift out PI[0] first.
- FILL, 1'b0: bit value shifted into the vacated end of the register on each shift.

Ports:
- C  input  1  clock; all state changes on rising edge.
- RST_N  input  1  asynchronous active-low reset; tie high if unused.
- PI  input  32  parallel word; sampled only on a load edge.
- SO  output  1  serial data out; equals the outgoing end of the shift register (bit 31 when MSB_FIRST=1).
- FS  output  1  frame start: high while SO carries the first bit of a frame.
- LB  output  1  last bit: high while SO carries the final bit of a frame.
- BIT_CNT  output  5  index of the frame bit currently on SO, 0..31.
- VALID  output  1  low from reset until the first load; high thereafter.

Behaviour:
- State: 32-bit data register SR, 5-bit counter CNT, flag LOADED.
- Reset:
  - RST_N=0 asynchronously forces SR=0, CNT=0, LOADED=0.
  - Outputs during reset: SO=0, FS=0, LB=0, BIT_CNT=0, VALID=0.
- Load edge is a rising edge of C where LOADED=0, or where LOADED=1 and CNT=31. On a load edge:
  - SR <= PI; CNT <= 0; LOADED <= 1.
- Shift edge is any other rising edge with LOADED=1:
  - MSB_FIRST=1: SR <= {SR[30:0], FILL}.
  - MSB_FIRST=0: SR <= {FILL, SR[31:1]}.
  - CNT <= CNT+1.
- Outputs (all registered-state derived, no combinational path from PI):
  - SO = SR[31] (MSB_FIRST=1) or SR[0] (MSB_FIRST=0).
  - VALID = LOADED.
  - FS = LOADED & (CNT==0).
  - LB = LOADED & (CNT==31).
  - BIT_CNT = CNT.
- Latency: first rising edge after RST_N deasserts loads PI. Immediately after that edge, SO = PI[31] (MSB_FIRST=1). Bit k of the frame appears on SO after the load edge plus k further edges.
- Frame period is exactly 32 clocks. PI[0] is on SO during the cycle with LB=1, and the next edge reloads PI with no idle cycle.
- PI changes between load edges are ignored; the word in flight is never corrupted.
- Reset mid-frame aborts the frame immediately. The next edge after release performs a fresh load.
- RST_N deasserting coincident with a clock edge: that edge is not required to load; the load may occur on the following edge.
- CNT never exceeds 31; there is no wrap other than the reload.

Test Plan:
- Hold RST_N=0, PI=32'hD0492087, toggle C -> SO=0, VALID=0, FS=0, LB=0, BIT_CNT=0 throughout.
- Release RST_N, PI=32'hD0492087, clock 32 edges -> VALID=1 after the first edge.
  - SO sequence 1,1,0,1,0,0,0,0,0,1,0,0,1,0,0,1,0,0,1,0,0,0,0,0,1,0,0,0,0,1,1,1.
  - FS=1 only on the first bit; LB=1 only on the 32nd bit; BIT_CNT steps 0..31.
- Continue clocking with PI unchanged -> the 33rd edge reloads with no gap: SO=1, FS=1, BIT_CNT=0, and the sequence repeats identically.
- Change PI to 32'h0000_0001 at BIT_CNT=5 of a frame:
  - The current frame continues with the 32'hD0492087 bits.
  - The next frame outputs 31 zeros then 1, with LB=1 on the 1.
- Assert RST_N=0 asynchronously at BIT_CNT=12, between edges -> SO, BIT_CNT, VALID drop to 0 without waiting for an edge. After release, the first edge loads the current PI and SO=PI[31].
- PI=32'hFFFF_FFFF then 32'h0000_0000 on consecutive frames -> 32 ones then 32 zeros on SO, confirming no stale bits or FILL leakage across the reload boundary.
